// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: one controller command port shared by a burst reader and a burst writer (optional stats: SDRAM_ARBITER_STATS_EN).
// Latency: grant is combinational in IDLE, the command follows one cycle later; word strobes and done pulses are combinational.
// Backpressure: requests wait until IDLE; a granted burst is never preempted; the controller paces words by its strobes.
module sdram_port_arbiter #(
  parameter int BURST_LENGTH  = 8,
  parameter int ADDRESS_WIDTH = 22,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_req,
  input  logic                     rd_urgent,
  input  logic [ADDRESS_WIDTH-1:0] rd_address,
  output logic                     rd_grant,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_data_valid,
  output logic                     rd_done,
  input  logic                     wr_req,
  input  logic [ADDRESS_WIDTH-1:0] wr_address,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     wr_grant,
  output logic                     wr_data_ack,
  output logic                     wr_done,
  output logic [1:0]               ctrl_command,
  output logic [ADDRESS_WIDTH-1:0] ctrl_address,
  output logic [DATA_WIDTH-1:0]    ctrl_write_data,
  input  logic [DATA_WIDTH-1:0]    ctrl_read_data,
  input  logic                     ctrl_read_valid,
  input  logic                     ctrl_write_done
`ifdef SDRAM_ARBITER_STATS_EN
  ,
  output logic [31:0]              rd_burst_count,
  output logic [31:0]              wr_burst_count
`endif
);

  localparam int CW = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(BURST_LENGTH - 1);

  // State encoding doubles as the controller command code.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_WRITE = 1'b0,
    OWN_READ  = 1'b1
  } owner_t;

  state_t                   state_q, state_d;
  owner_t                   last_owner_q, last_owner_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     pick_rd, pick_wr;
  logic                     word_strobe, last_word;

  always_comb begin
    pick_rd = 1'b0;
    pick_wr = 1'b0;
    if (state_q == ST_IDLE) begin
      pick_rd = rd_req & (rd_urgent | ~wr_req | (last_owner_q == OWN_WRITE));
      pick_wr = wr_req & ~pick_rd;
    end
  end

  always_comb begin
    word_strobe = 1'b0;
    case (state_q)
      ST_WRITE: word_strobe = ctrl_write_done;
      ST_READ:  word_strobe = ctrl_read_valid;
      default:  word_strobe = 1'b0;
    endcase
    last_word = word_strobe & (count_q == LAST_WORD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWN_WRITE;
      addr_q       <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    count_d      = count_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_rd) begin
          state_d      = ST_READ;
          last_owner_d = OWN_READ;
          addr_d       = rd_address;
          count_d      = '0;
        end else if (pick_wr) begin
          state_d      = ST_WRITE;
          last_owner_d = OWN_WRITE;
          addr_d       = wr_address;
          count_d      = '0;
        end
      end
      ST_WRITE, ST_READ: begin
        if (word_strobe) begin
          addr_d  = addr_q + ADDRESS_WIDTH'(1);
          count_d = last_word ? '0 : count_q + CW'(1);
          if (last_word) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_grant        = pick_rd;
    wr_grant        = pick_wr;
    rd_data_valid   = (state_q == ST_READ) & ctrl_read_valid;
    wr_data_ack     = (state_q == ST_WRITE) & ctrl_write_done;
    rd_done         = (state_q == ST_READ) & last_word;
    wr_done         = (state_q == ST_WRITE) & last_word;
    ctrl_command    = state_q;
    ctrl_address    = addr_q;
    ctrl_write_data = wr_data;
    rd_data         = ctrl_read_data;
  end

`ifdef SDRAM_ARBITER_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_done) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (wr_done) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_burst_count = rd_cnt_q;
  assign wr_burst_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios then random traffic, all checked against a burst-level model.
module tb_sdram_port_arbiter;
  localparam int     BL   = 8;
  localparam int     AW   = 22;
  localparam int     DW   = 16;
  localparam longint AMOD = 64'd1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_req, rd_urgent, wr_req;
  logic [AW-1:0] rd_address, wr_address;
  logic [DW-1:0] wr_data, ctrl_read_data;
  logic          ctrl_read_valid, ctrl_write_done;
  logic          rd_grant, rd_data_valid, rd_done;
  logic          wr_grant, wr_data_ack, wr_done;
  logic [DW-1:0] rd_data, ctrl_write_data;
  logic [1:0]    ctrl_command;
  logic [AW-1:0] ctrl_address;
`ifdef SDRAM_ARBITER_STATS_EN
  logic [31:0]   rd_burst_count, wr_burst_count;
`endif

  always #5 clk = ~clk;

  sdram_port_arbiter #(.BURST_LENGTH(BL), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_urgent(rd_urgent), .rd_address(rd_address),
    .rd_grant(rd_grant), .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_done(rd_done),
    .wr_req(wr_req), .wr_address(wr_address), .wr_data(wr_data),
    .wr_grant(wr_grant), .wr_data_ack(wr_data_ack), .wr_done(wr_done),
    .ctrl_command(ctrl_command), .ctrl_address(ctrl_address), .ctrl_write_data(ctrl_write_data),
    .ctrl_read_data(ctrl_read_data), .ctrl_read_valid(ctrl_read_valid), .ctrl_write_done(ctrl_write_done)
`ifdef SDRAM_ARBITER_STATS_EN
    , .rd_burst_count(rd_burst_count), .wr_burst_count(wr_burst_count)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Burst-level model: mode 0 idle / 1 write / 2 read, start address, words transferred so far.
  int     m_mode, m_words, m_last, m_rd_bursts, m_wr_bursts;
  longint m_start;

  logic          obs_rd_grant, obs_wr_grant, obs_rd_done, obs_wr_done;
  logic [1:0]    obs_cmd;
  logic [AW-1:0] obs_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_start = 0; m_words = 0; m_last = 1;
    m_rd_bursts = 0; m_wr_bursts = 0;
  endtask

  task automatic cycle();
    int   pick;
    logic e_rv, e_wa, e_rd, e_wd;
    @(negedge clk);
    pick = 0;
    if (m_mode == 0) begin
      if (rd_req && rd_urgent)  pick = 2;
      else if (rd_req && wr_req) pick = (m_last == 1) ? 2 : 1;
      else if (rd_req)          pick = 2;
      else if (wr_req)          pick = 1;
    end
    e_rv = (m_mode == 2) && ctrl_read_valid;
    e_wa = (m_mode == 1) && ctrl_write_done;
    e_rd = e_rv && (m_words == BL - 1);
    e_wd = e_wa && (m_words == BL - 1);
    obs_rd_grant = rd_grant; obs_wr_grant = wr_grant;
    obs_rd_done  = rd_done;  obs_wr_done  = wr_done;
    obs_cmd      = ctrl_command; obs_addr = ctrl_address;
    check("command", ctrl_command, m_mode);
    check("address", ctrl_address, (m_start + m_words) % AMOD);
    check("rd_grant", rd_grant, pick == 2);
    check("wr_grant", wr_grant, pick == 1);
    check("rd_data_valid", rd_data_valid, e_rv);
    check("wr_data_ack", wr_data_ack, e_wa);
    check("rd_done", rd_done, e_rd);
    check("wr_done", wr_done, e_wd);
    check("rd_data", rd_data, ctrl_read_data);
    check("ctrl_write_data", ctrl_write_data, wr_data);
`ifdef SDRAM_ARBITER_STATS_EN
    check("rd_burst_count", rd_burst_count, 32'(m_rd_bursts));
    check("wr_burst_count", wr_burst_count, 32'(m_wr_bursts));
`endif
    if (reset) begin
      model_reset();
    end else if (pick != 0) begin
      m_mode  = pick;
      m_last  = pick;
      m_start = (pick == 2) ? longint'(rd_address) : longint'(wr_address);
      m_words = 0;
    end else if (e_rv || e_wa) begin
      m_words++;
      if (m_words == BL) begin
        if (m_mode == 2) m_rd_bursts++;
        else             m_wr_bursts++;
        m_mode = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rd_req = 0; rd_urgent = 0; wr_req = 0;
    ctrl_read_valid = 0; ctrl_write_done = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  task automatic do_burst(input int rd, input logic [AW-1:0] a);
    logic got;
    got = 0;
    if (rd != 0) begin rd_req = 1; rd_address = a; end
    else         begin wr_req = 1; wr_address = a; end
    for (int k = 0; k < 20 && !got; k++) begin
      cycle();
      got = (rd != 0) ? obs_rd_grant : obs_wr_grant;
    end
    check("grant_seen", got, 1'b1);
    rd_req = 0; wr_req = 0;
    for (int k = 0; k < BL; k++) begin
      if (rd != 0) begin ctrl_read_valid = 1; ctrl_read_data = DW'($urandom); end
      else         begin ctrl_write_done = 1; wr_data = DW'($urandom); end
      cycle();
      check("burst_word_addr", obs_addr, (longint'(a) + k) % AMOD);
      check("burst_done_last", (rd != 0) ? obs_rd_done : obs_wr_done, k == BL - 1);
    end
    ctrl_read_valid = 0; ctrl_write_done = 0;
    cycle();
    check("burst_idle_cmd", obs_cmd, 2'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    logic seen;
    clear_inputs();
    rd_address = '0; wr_address = '0; wr_data = '0; ctrl_read_data = '0;
    reset = 1;
    @(posedge clk);
    #1;
    model_reset();
    cycle();
    check("reset_cmd", obs_cmd, 2'd0);
    check("reset_addr", obs_addr, 0);
    reset = 0;

    // Write burst wrapping the top of the address space.
    do_burst(0, 22'h3FFFFE);

    // Plain read burst.
    do_burst(1, 22'h000100);

    // Both requesting, not urgent: strict alternation starting with read.
    do_reset();
    rd_req = 1; wr_req = 1; rd_address = 22'h000400; wr_address = 22'h000800;
    ctrl_read_valid = 1; ctrl_write_done = 1;
    for (int k = 0; k < 45; k++) begin
      cycle();
      if (obs_rd_grant) order.push_back(2);
      if (obs_wr_grant) order.push_back(1);
    end
    clear_inputs();
    cycle();
    for (int i = 0; i < 4; i++)
      check("rr_order", (i < order.size()) ? order[i] : 0, (i % 2 == 0) ? 2 : 1);
    do_reset();

    // Urgent read arrives mid-write: write finishes, read granted in the first idle cycle.
    wr_req = 1; wr_address = 22'h001230;
    cycle();
    check("t4_wr_grant", obs_wr_grant, 1'b1);
    wr_req = 0;
    ctrl_write_done = 1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cycle();
      seen = obs_wr_done;
      if (k == 2) begin rd_req = 1; rd_urgent = 1; rd_address = 22'h000200; end
    end
    check("t4_wr_done_seen", seen, 1'b1);
    ctrl_write_done = 0;
    cycle();
    check("t4_rd_grant_after_done", obs_rd_grant, 1'b1);
    check("t4_idle_cmd", obs_cmd, 2'd0);
    rd_req = 0; rd_urgent = 0;
    ctrl_read_valid = 1;
    for (int k = 0; k < BL; k++) cycle();
    ctrl_read_valid = 0;
    cycle();

    // Reset after three read words aborts the burst silently.
    rd_req = 1; rd_address = 22'h000300;
    cycle();
    rd_req = 0;
    ctrl_read_valid = 1;
    for (int k = 0; k < 3; k++) cycle();
    ctrl_read_valid = 0;
    reset = 1;
    cycle();
    reset = 0;
    cycle();
    check("t5_cmd_after_reset", obs_cmd, 2'd0);
    check("t5_addr_after_reset", obs_addr, 0);
    check("t5_no_rd_done", obs_rd_done, 1'b0);
    do_burst(1, 22'h000040);

`ifdef SDRAM_ARBITER_STATS_EN
    do_reset();
    for (int k = 0; k < 3; k++) do_burst(0, AW'(k * 16));
    for (int k = 0; k < 2; k++) do_burst(1, AW'(k * 16 + 64));
    cycle();
    check("stats_wr", wr_burst_count, 32'd3);
    check("stats_rd", rd_burst_count, 32'd2);
`endif

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      rd_req          = ($urandom_range(0, 2) != 0);
      wr_req          = ($urandom_range(0, 2) != 0);
      rd_urgent       = ($urandom_range(0, 4) == 0);
      ctrl_read_valid = ($urandom_range(0, 4) < 3);
      ctrl_write_done = ($urandom_range(0, 4) < 3);
      rd_address      = ($urandom_range(0, 3) == 0) ? AW'(AMOD - $urandom_range(1, 8)) : AW'($urandom);
      wr_address      = ($urandom_range(0, 3) == 0) ? AW'(AMOD - $urandom_range(1, 8)) : AW'($urandom);
      wr_data         = DW'($urandom);
      ctrl_read_data  = DW'($urandom);
      cycle();
    end
    clear_inputs();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
